ram_nr_mw: RTL



---
 rtl/ram_pkg.sv | 42 ++++
 rtl/ram_entry.sv | 26 ++
 rtl/ram_nr_mw.sv | 88 ++++++++
 3 files changed

// File: rtl/ram_pkg.sv
// Shared types and write-port arbitration for the multi-port register array.
package ram_pkg;

    localparam int DEF_OPRAND_WIDTH  = 32;
    localparam int DEF_ARRAY_ENTRY   = 32;
    localparam int DEF_REGNAME_WIDTH = 5;
    localparam int DEF_NUM_RD        = 4;
    localparam int DEF_NUM_WR        = 2;

    // The arbitration function works on fixed-width padded vectors so any
    // instance with NUM_WR <= MAX_WR and REGNAME_WIDTH <= MAX_AW can share it.
    localparam int MAX_WR = 16;
    localparam int MAX_AW = 16;
    localparam int PORT_W = 4;

    typedef logic [DEF_REGNAME_WIDTH-1:0] reg_addr_t;
    typedef logic [DEF_OPRAND_WIDTH-1:0]  oprand_t;
    typedef logic [MAX_AW-1:0]            sel_addr_t;

    typedef struct packed {
        logic              hit;
        logic [PORT_W-1:0] port;
    } wr_sel_t;

    // Ascending scan so the highest-numbered matching port is the one kept.
    function automatic wr_sel_t wr_select(
        input sel_addr_t                      addr,
        input logic [MAX_WR-1:0][MAX_AW-1:0]  wa,
        input logic [MAX_WR-1:0]              we
    );
        wr_sel_t r;
        r = '0;
        for (int k = 0; k < MAX_WR; k++) begin
            if (we[k] && (wa[k] == addr)) begin
                r.hit  = 1'b1;
                r.port = PORT_W'(k);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/ram_entry.sv
// One storage row of the register array with its operand-valid bit.
module ram_entry #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         inv_en,
    output logic [W-1:0] data,
    output logic         valid
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data  <= '0;
            valid <= 1'b1;
        end else begin
            if (wr_en) data <= wr_data;
            // An invalidate names a newer producer, so it outranks a write.
            if (inv_en)     valid <= 1'b0;
            else if (wr_en) valid <= 1'b1;
        end
    end

endmodule

// File: rtl/ram_nr_mw.sv
// Parametrised NUM_RD-read / NUM_WR-write register array with valid scoreboard.
// Optional macro RAM_BYPASS_EN adds same-cycle write-to-read forwarding.
module ram_nr_mw
    import ram_pkg::*;
#(
    parameter int OPRAND_WIDTH  = DEF_OPRAND_WIDTH,
    parameter int ARRAY_ENTRY   = DEF_ARRAY_ENTRY,
    parameter int REGNAME_WIDTH = DEF_REGNAME_WIDTH,
    parameter int NUM_RD        = DEF_NUM_RD,
    parameter int NUM_WR        = DEF_NUM_WR
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_WR-1:0][OPRAND_WIDTH-1:0]   write_data_i,
    input  logic [NUM_WR-1:0][REGNAME_WIDTH-1:0]  write_addr_i,
    input  logic [NUM_WR-1:0]                     write_en_i,
    input  logic                                  inv_en_i,
    input  logic [REGNAME_WIDTH-1:0]              inv_addr_i,
    input  logic [NUM_RD-1:0][REGNAME_WIDTH-1:0]  read_addr_i,
    input  logic [NUM_RD-1:0]                     read_en_i,
    output logic [NUM_RD-1:0][OPRAND_WIDTH-1:0]   read_data_o,
    output logic [NUM_RD-1:0]                     read_ready_o,
    output logic [ARRAY_ENTRY-1:0]                valid_o
);

    logic [ARRAY_ENTRY-1:0][OPRAND_WIDTH-1:0] mem;
    logic [MAX_WR-1:0][MAX_AW-1:0]            wa_pad;
    logic [MAX_WR-1:0]                        we_pad;

    always_comb begin
        wa_pad = '0;
        we_pad = '0;
        for (int k = 0; k < NUM_WR; k++) begin
            wa_pad[k] = MAX_AW'(write_addr_i[k]);
            we_pad[k] = write_en_i[k];
        end
    end

    for (genvar e = 0; e < ARRAY_ENTRY; e++) begin : g_ent
        wr_sel_t                 sel;
        logic [OPRAND_WIDTH-1:0] wd;
        logic                    inv;

        assign sel = wr_select(MAX_AW'(e), wa_pad, we_pad);
        assign inv = inv_en_i && (inv_addr_i == REGNAME_WIDTH'(e));

        always_comb begin
            wd = '0;
            for (int k = 0; k < NUM_WR; k++)
                if (sel.port == PORT_W'(k)) wd = write_data_i[k];
        end

        ram_entry #(.W(OPRAND_WIDTH)) u_ent (
            .clk     (clk),
            .rst     (rst),
            .wr_en   (sel.hit),
            .wr_data (wd),
            .inv_en  (inv),
            .data    (mem[e]),
            .valid   (valid_o[e])
        );
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [OPRAND_WIDTH-1:0] rd;
        logic                    rdy;
`ifdef RAM_BYPASS_EN
        wr_sel_t bsel;
        assign bsel = wr_select(MAX_AW'(read_addr_i[p]), wa_pad, we_pad);
`endif

        always_comb begin
            rd  = mem[read_addr_i[p]];
            rdy = valid_o[read_addr_i[p]];
`ifdef RAM_BYPASS_EN
            // Writes are discarded while reset is held, so never forward them.
            if (bsel.hit && rst) begin
                for (int k = 0; k < NUM_WR; k++)
                    if (bsel.port == PORT_W'(k)) rd = write_data_i[k];
                if (!(inv_en_i && (inv_addr_i == read_addr_i[p]))) rdy = 1'b1;
            end
`endif
            read_data_o[p]  = read_en_i[p] ? rd : '0;
            read_ready_o[p] = read_en_i[p] & rdy;
        end
    end

endmodule
